ifetch_prefetch: RTL

Parametrised instruction-fetch unit with a prefetch queue, replacing the single-register PC fetch stage. It streams sequential instruction words from a synchronous instruction ROM into a DEPTH-entry queue. It hands them to decode over a valid/ready handshake with their PC and link address. All control transfers (branch, jump, jal, jr) arrive as one redirect computed downstream, which flushes the queue and restarts fetch at the target.

---
 rtl/ifetch_prefetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue fed by a synchronous ROM.
// Redirects (and reset) flush the queue and discard any read still in flight.
module ifetch_prefetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 IMEM_AW  = 14,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_en,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic [ADDR_W-1:0]   link_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_INC  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~(ADDR_W'(3));

    logic [ADDR_W-1:0] fpc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [31:0]       q_inst_r [DEPTH];
    logic [ADDR_W-1:0] q_pc_r   [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              valid_r;
    logic [31:0]       inst_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] link_r;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CNT_W:0]    credit_s;
    logic [CNT_W-1:0]  count_after_pop_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [PTR_W-1:0]  head_next_s;
    logic [ADDR_W-1:0] target_s;
    logic              nxt_valid_s;
    logic [31:0]       nxt_inst_s;
    logic [ADDR_W-1:0] nxt_pc_s;

    // Handshake, credit-based issue decision and queue bookkeeping.
    always_comb begin
        pop_s             = valid_r & inst_ready;
        push_s            = inflight_r & ~redirect;
        credit_s          = {1'b0, count_r} + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
        issue_s           = ~reset & ~redirect & (credit_s < DEPTH_C);
        count_after_pop_s = count_r - CNT_W'(pop_s);
        count_next_s      = count_after_pop_s + CNT_W'(push_s);
        head_next_s       = head_r + PTR_W'(pop_s);
        target_s          = redirect_pc & ALIGN_MSK;
    end

    // Next head entry; an empty-after-pop queue takes the word being pushed this cycle.
    always_comb begin
        nxt_valid_s = 1'b0;
        nxt_inst_s  = 32'h0000_0000;
        nxt_pc_s    = {ADDR_W{1'b0}};
        if (count_next_s == {CNT_W{1'b0}}) begin
            nxt_valid_s = 1'b0;
        end else if (count_after_pop_s == {CNT_W{1'b0}}) begin
            nxt_valid_s = 1'b1;
            nxt_inst_s  = imem_rdata;
            nxt_pc_s    = inflight_pc_r;
        end else begin
            nxt_valid_s = 1'b1;
            nxt_inst_s  = q_inst_r[head_next_s];
            nxt_pc_s    = q_pc_r[head_next_s];
        end
    end

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_r         <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
        end else if (redirect) begin
            fpc_r      <= target_s;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fpc_r         <= fpc_r + WORD_INC;
                inflight_pc_r <= fpc_r;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_r + PTR_W'(push_s);
            count_r <= count_next_s;
        end
    end

    // Queue storage; credit accounting guarantees the tail slot is free on a push.
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            q_inst_r[tail_r] <= imem_rdata;
            q_pc_r[tail_r]   <= inflight_pc_r;
        end
    end

    // Registered head presentation to decode.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            valid_r <= 1'b0;
            inst_r  <= 32'h0000_0000;
            pc_r    <= {ADDR_W{1'b0}};
            link_r  <= {ADDR_W{1'b0}};
        end else begin
            valid_r <= nxt_valid_s;
            inst_r  <= nxt_inst_s;
            pc_r    <= nxt_pc_s;
            link_r  <= nxt_valid_s ? (nxt_pc_s + WORD_INC) : {ADDR_W{1'b0}};
        end
    end

    assign imem_en    = issue_s;
    assign imem_addr  = fpc_r[IMEM_AW+1:2];
    assign inst_valid = valid_r;
    assign inst       = inst_r;
    assign inst_pc    = pc_r;
    assign link_addr  = link_r;

endmodule
